stream_distributor: RTL and testbench

Routes a single inbound node-message stream to one of up to four outbound streams (North/East/South/West) selected by a per-message direction tag. Each outbound stream has its own small buffer, so a stalled output does not block messages bound elsewhere. Sits at a node's egress, between message generation and the per-direction link interfaces, and reports an idle flag for drain detection.

---
 rtl/stream_distributor_pkg.sv | 21 ++
 rtl/stream_distributor_fifo.sv | 56 +++++
 rtl/stream_distributor.sv | 57 +++++
 tb/tb_stream_distributor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_distributor_pkg.sv
// Shared node-level types: direction tags and the message word carried between nodes.
package NXConstants;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    SOUTH = 2'd2,
    WEST  = 2'd3
  } direction_t;

  localparam int MESSAGE_WIDTH = 32;
  localparam int MAX_STREAMS   = 4;

  typedef logic [MESSAGE_WIDTH-1:0] node_message_t;

  // True when the tag names a stream that physically exists in this build.
  function automatic logic dir_in_range(input direction_t dir, input int streams);
    return int'(dir) < streams;
  endfunction

endpackage

// File: rtl/stream_distributor_fifo.sv
// Small per-stream FIFO: wrapping read/write pointers plus an occupancy count.
// The head reads as zero when empty so idle streams present a clean bus.
module nx_fifo
  import NXConstants::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = MESSAGE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic                        do_push;
  logic                        do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/stream_distributor.sv
// Fans one inbound message stream out to per-direction buffered streams.
// Only the direction decode and ready mux live here; buffering is in nx_fifo.
module stream_distributor
  import NXConstants::*;
#(
  parameter int STREAMS = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  output logic                                  o_idle,
  input  direction_t                            i_inbound_dir,
  input  node_message_t                         i_inbound_data,
  input  logic                                  i_inbound_valid,
  output logic                                  o_inbound_ready,
  output logic [STREAMS-1:0][MESSAGE_WIDTH-1:0] o_outbound_data,
  output logic [STREAMS-1:0]                    o_outbound_valid,
  input  logic [STREAMS-1:0]                    i_outbound_ready
);

  logic [STREAMS-1:0] push;
  logic [STREAMS-1:0] pop;
  logic [STREAMS-1:0] full;
  logic [STREAMS-1:0] empty;

  for (genvar d = 0; d < STREAMS; d++) begin : g_stream
    assign push[d] = i_inbound_valid & (i_inbound_dir == direction_t'(d));
    assign pop[d]  = ~empty[d] & i_outbound_ready[d];
    assign o_outbound_valid[d] = ~empty[d];

    nx_fifo #(
      .DEPTH (2),
      .WIDTH (MESSAGE_WIDTH)
    ) u_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst),
      .push      (push[d]),
      .push_data (i_inbound_data),
      .pop       (pop[d]),
      .full      (full[d]),
      .empty     (empty[d]),
      .head      (o_outbound_data[d])
    );
  end

  // Tags beyond the built streams are sunk: ready stays high and nothing is stored.
  always_comb begin
    o_inbound_ready = 1'b1;
    if (dir_in_range(i_inbound_dir, STREAMS)) begin
      for (int d = 0; d < STREAMS; d++) begin
        if (i_inbound_dir == direction_t'(d)) o_inbound_ready = ~full[d];
      end
    end
  end

  assign o_idle = &empty;

endmodule

// File: tb/tb_stream_distributor.sv
// Scoreboarded bench for stream_distributor: per-stream expected queues fed on
// inbound handshakes and drained on outbound handshakes.
module tb_stream_distributor;
  import NXConstants::*;

  localparam int S = 4;

  logic                            clk;
  logic                            rst;
  logic                            idle;
  direction_t                      in_dir;
  node_message_t                   in_data;
  logic                            in_valid;
  logic                            in_ready;
  logic [S-1:0][MESSAGE_WIDTH-1:0] out_data;
  logic [S-1:0]                    out_valid;
  logic [S-1:0]                    out_ready;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  node_message_t exp_q [S][$];
  logic [S-1:0]  prev_stall;
  node_message_t prev_data [S];

  stream_distributor #(.STREAMS(S)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_idle           (idle),
    .i_inbound_dir    (in_dir),
    .i_inbound_data   (in_data),
    .i_inbound_valid  (in_valid),
    .o_inbound_ready  (in_ready),
    .o_outbound_data  (out_data),
    .o_outbound_valid (out_valid),
    .i_outbound_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = '0;
    end else begin
      for (int d = 0; d < S; d++) begin
        if (prev_stall[d]) begin
          chk_cnt++;
          if (out_valid[d] === 1'b1 && out_data[d] === prev_data[d]) pass_cnt++;
          else $display("FAIL hold_s%0d: valid=%b data=%h, required valid=1 data=%h",
                        d, out_valid[d], out_data[d], prev_data[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          chk_cnt++;
          if (exp_q[d].size() == 0) begin
            $display("FAIL pop_s%0d: unexpected data=%h, required nothing", d, out_data[d]);
          end else begin
            node_message_t e;
            e = exp_q[d].pop_front();
            if (out_data[d] === e) pass_cnt++;
            else $display("FAIL pop_s%0d: data=%h, required %h", d, out_data[d], e);
          end
        end
        prev_stall[d] = out_valid[d] & ~out_ready[d];
        prev_data[d]  = out_data[d];
      end
      if (in_valid && in_ready && int'(in_dir) < S) exp_q[int'(in_dir)].push_back(in_data);
    end
  end

  task automatic send(input direction_t dir, input node_message_t data);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_dir   = dir;
    in_data  = data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL send_timeout: ready=%b after 20 cycles, required 1", in_ready);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_dir = NORTH; in_data = '0; out_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt += 4;
    if (idle === 1'b1) pass_cnt++; else $display("FAIL rst_idle: got %b, required 1", idle);
    if (out_valid === '0) pass_cnt++; else $display("FAIL rst_valid: got %b, required 0", out_valid);
    if (out_data === '0) pass_cnt++; else $display("FAIL rst_data: got %h, required 0", out_data);
    if (in_ready === 1'b1) pass_cnt++; else $display("FAIL rst_ready: got %b, required 1", in_ready);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt += 3;
    if (idle === 1'b1) pass_cnt++; else $display("FAIL post_rst_idle: got %b, required 1", idle);
    if (out_valid === '0) pass_cnt++; else $display("FAIL post_rst_valid: got %b, required 0", out_valid);
    if (out_data === '0) pass_cnt++; else $display("FAIL post_rst_data: got %h, required 0", out_data);
  endtask

  task automatic test_routing();
    direction_t    dirs [4] = '{NORTH, EAST, SOUTH, WEST};
    node_message_t msgs [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      send(dirs[i], msgs[i]);
      chk_cnt++;
      if (out_valid[i] === 1'b1 && out_data[i] === msgs[i]) pass_cnt++;
      else $display("FAIL route_%0d: valid=%b data=%h, required valid=1 data=%h",
                    i, out_valid[i], out_data[i], msgs[i]);
    end
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (idle === 1'b1) pass_cnt++; else $display("FAIL route_idle: got %b, required 1", idle);
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1110;
    send(NORTH, 32'h11);
    send(NORTH, 32'h12);
    in_valid = 1'b1; in_dir = NORTH; in_data = 32'h13;
    @(negedge clk);
    chk_cnt++;
    if (in_ready === 1'b0) pass_cnt++; else $display("FAIL bp_north_full: ready=%b, required 0", in_ready);
    @(posedge clk); #1;
    in_dir = EAST; in_data = 32'h21;
    @(negedge clk);
    chk_cnt++;
    if (in_ready === 1'b1) pass_cnt++; else $display("FAIL bp_east_ready: ready=%b, required 1", in_ready);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid[0] === 1'b1 && out_data[0] === 32'h11) pass_cnt++;
    else $display("FAIL bp_north_head: valid=%b data=%h, required valid=1 data=11", out_valid[0], out_data[0]);
    out_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (idle === 1'b1) pass_cnt++; else $display("FAIL bp_idle: got %b, required 1", idle);
  endtask

  task automatic test_no_bypass();
    out_ready = '0;
    send(SOUTH, 32'h31);
    send(SOUTH, 32'h32);
    out_ready[2] = 1'b1;
    in_valid = 1'b1; in_dir = SOUTH; in_data = 32'h33;
    @(negedge clk);
    chk_cnt++;
    if (in_ready === 1'b0) pass_cnt++; else $display("FAIL nobypass_full: ready=%b, required 0", in_ready);
    @(posedge clk); #1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready === 1'b1) pass_cnt++; else $display("FAIL nobypass_next: ready=%b, required 1", in_ready);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (idle === 1'b1) pass_cnt++; else $display("FAIL nobypass_idle: got %b, required 1", idle);
  endtask

  task automatic test_random();
    int left;
    out_ready = '1;
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_dir   = direction_t'($urandom_range(0, 3));
      in_data  = $urandom;
      if (i >= 1000) out_ready = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = '1;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(posedge clk); #1;
    end
    left = 0;
    for (int d = 0; d < S; d++) left += exp_q[d].size();
    chk_cnt += 2;
    if (idle === 1'b1) pass_cnt++; else $display("FAIL rand_idle: got %b, required 1", idle);
    if (left == 0) pass_cnt++; else $display("FAIL rand_undelivered: %0d left, required 0", left);
  endtask

  task automatic test_mid_reset();
    int bad;
    out_ready = '0;
    send(WEST, 32'h41);
    send(WEST, 32'h42);
    chk_cnt++;
    if (out_valid[3] === 1'b1) pass_cnt++; else $display("FAIL mr_buffered: valid=%b, required 1", out_valid[3]);
    #2 rst = 1'b0;
    for (int d = 0; d < S; d++) exp_q[d].delete();
    #1;
    chk_cnt += 3;
    if (out_valid === '0) pass_cnt++; else $display("FAIL mr_valid: got %b, required 0", out_valid);
    if (idle === 1'b1) pass_cnt++; else $display("FAIL mr_idle: got %b, required 1", idle);
    if (out_data === '0) pass_cnt++; else $display("FAIL mr_data: got %h, required 0", out_data);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = '1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== '0) bad++;
    end
    chk_cnt++;
    if (bad == 0) pass_cnt++; else $display("FAIL mr_emitted: %0d cycles with valid, required 0", bad);
  endtask

  initial begin
    prev_stall = '0;
    test_reset();
    test_routing();
    test_backpressure();
    test_no_bypass();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
